run_length_detector: RTL
========================

Name: run_length_detector

Overview:
- Detects a run of RUN_LEN consecutive identical symbols, each SYM_W bits wide, on a valid-qualified input stream.
- Emits a one-cycle hit pulse with the matching symbol value, plus a saturating hit counter for status and debug.
- Supports overlapping and non-overlapping detection.
- A mismatching symbol starts a new run of length 1; it is never discarded.
- Sits between the serial front-end and the control/status block.

Parameters:
- SYM_W, 1, symbol width in bits (>=1).
- RUN_LEN, 3, number of identical consecutive symbols that constitute a hit (>=2).
- CNT_W, 8, width of the hit counter (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_sym is accepted on a rising edge only when 1.
- in_sym  input  SYM_W  input symbol.
- overlap  input  1  1 = overlapping detection, 0 = restart after hit; sampled with each accepted symbol.
- clear  input  1  synchronous clear of hit_count.
- hit  output  1  registered one-cycle pulse: run completed.
- hit_sym  output  SYM_W  symbol of the completed run; valid while hit=1, holds its last value otherwise.
- run_cnt  output  RW  current run length, where RW = clog2(RUN_LEN+1).
- hit_count  output  CNT_W  saturating number of hits since reset or clear.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. While reset=1: state=IDLE, hit=0, hit_sym=0, run_cnt=0, hit_count=0, last_sym=0. Reset mid-run discards the partial run.
- States: IDLE (no symbol held), RUN (1 <= run_cnt <= RUN_LEN-1), FULL (run_cnt = RUN_LEN; reachable only with overlap=1).
- in_valid=0: state, run_cnt and last_sym hold; hit=0 next cycle.
- IDLE + valid: last_sym <= in_sym, run_cnt <= 1, go to RUN.
- RUN + valid, in_sym != last_sym: last_sym <= in_sym, run_cnt <= 1, stay in RUN.
- RUN + valid, in_sym == last_sym, run_cnt+1 < RUN_LEN: run_cnt++, stay in RUN.
- RUN + valid, in_sym == last_sym, run_cnt+1 == RUN_LEN: hit <= 1, hit_sym <= in_sym. Then:
  - overlap=1: go to FULL, run_cnt <= RUN_LEN.
  - overlap=0: go to IDLE, run_cnt <= 0.
- FULL + valid, in_sym == last_sym:
  - overlap=1: hit <= 1 again, stay in FULL.
  - overlap=0: no hit, go to RUN, run_cnt <= 1.
- FULL + valid, in_sym != last_sym: RUN, run_cnt <= 1, last_sym <= in_sym.
- Latency: hit is high for exactly the one cycle following the edge that accepted the completing symbol.
- Back-to-back hits in overlap mode produce a continuous hit=1 level, one pulse per accepted symbol.
- hit_count: increments by 1 on every hit and saturates at 2^CNT_W-1 with no wrap.
- clear=1 forces hit_count to 0 and takes priority over a simultaneous increment. A hit in that same cycle is still output on hit.
- Mode change: a change of overlap mid-run affects only the next accepted symbol; run_cnt is not altered by the change itself.

Decomposition:
- Package run_det_pkg contains:
  - state enum typedef {IDLE, RUN, FULL};
  - constant function for the RW width calculation.
- One sub-module, sat_counter (parameter CNT_W; ports inc, clr, count), instantiated for hit_count.
- FSM and run counter remain in run_length_detector.

Test Plan:
- SYM_W=1, RUN_LEN=3, overlap=0; feed 0,0,0,0,0,0 -> hit after 3rd and 6th symbols; hit_sym=0; hit_count=2; run_cnt sequence 1,2,0,1,2,0.
- Same config, overlap=1; feed 1,1,1,1,1 -> hit after 3rd, 4th and 5th symbols (hit high 3 consecutive cycles); run_cnt 1,2,3,3,3; hit_count=3.
- RUN_LEN=3; feed 0,0,1,1,1 -> single hit after 5th symbol with hit_sym=1; the mismatching 1 starts a run (run_cnt=1, not 0).
- SYM_W=4, RUN_LEN=4; feed 0xA,0xA, then in_valid=0 for 5 cycles, then 0xA,0xA -> one hit, hit_sym=0xA; gap cycles hold run_cnt=2 with hit=0.
- CNT_W=2, overlap=1, 10 identical symbols -> hit_count saturates at 3. clear asserted in the same cycle as a hit -> hit_count=0 and hit=1.
- Assert reset asynchronously (off a clock edge) with run_cnt=2 -> all outputs 0 immediately; the next two matching symbols give run_cnt=2 and no hit.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared definitions for the run-length detector.
//   state_t   : detector FSM states
//   run_cnt_w : width needed to hold a run length of 0..run_len
package run_det_pkg;

  // IDLE : no symbol held
  // RUN  : 1 <= run_cnt <= RUN_LEN-1
  // FULL : run_cnt == RUN_LEN; reached only in overlapping mode
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  function automatic int run_cnt_w(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hit counter.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset (count -> 0)
//   inc   : add one this cycle, unless already at all-ones
//   clr   : synchronous clear; wins over a simultaneous inc
//   count : current value; it stops at 2^CNT_W-1 and does not wrap
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/run_length_detector.sv
// Detects RUN_LEN consecutive identical symbols on a valid-qualified stream.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high reset
//   in_valid  : in_sym is accepted on a rising edge only when 1
//   in_sym    : input symbol (SYM_W bits)
//   overlap   : 1 = keep detecting inside a run, 0 = restart after a hit;
//               sampled together with each accepted symbol
//   clear     : synchronous clear of hit_count
//   hit       : registered one-cycle pulse per completed run
//   hit_sym   : symbol of the completed run; holds between hits
//   run_cnt   : current run length
//   hit_count : saturating count of hits since reset or clear
//   dbg_state : current FSM state, for observation
//
// Stream semantics: there is no back-pressure. A symbol is consumed on every
// rising edge where in_valid=1; when in_valid=0 nothing in the run tracker
// moves and hit drops the following cycle.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter  int SYM_W   = 1,
  parameter  int RUN_LEN = 3,
  parameter  int CNT_W   = 8,
  localparam int RW      = run_cnt_w(RUN_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             overlap,
  input  logic             clear,
  output logic             hit,
  output logic [SYM_W-1:0] hit_sym,
  output logic [RW-1:0]    run_cnt,
  output logic [CNT_W-1:0] hit_count,
  output state_t           dbg_state
);

  state_t           r_state;
  logic [RW-1:0]    r_run_cnt;
  logic [SYM_W-1:0] r_last_sym;
  logic             r_hit;
  logic [SYM_W-1:0] r_hit_sym;

  state_t           w_state_n;
  logic [RW-1:0]    w_run_cnt_n;
  logic [SYM_W-1:0] w_last_sym_n;
  logic             w_hit_n;
  logic [SYM_W-1:0] w_hit_sym_n;

  logic             w_same;
  logic [RW-1:0]    w_run_cnt_inc;
  logic             w_run_done;

  assign w_same        = (in_sym == r_last_sym);
  assign w_run_cnt_inc = r_run_cnt + RW'(1);
  // In RUN the count never exceeds RUN_LEN-1, so the increment cannot wrap.
  assign w_run_done    = (w_run_cnt_inc == RW'(RUN_LEN));

  always_comb begin
    w_state_n    = r_state;
    w_run_cnt_n  = r_run_cnt;
    w_last_sym_n = r_last_sym;
    w_hit_n      = 1'b0;
    w_hit_sym_n  = r_hit_sym;

    if (in_valid) begin
      case (r_state)
        IDLE: begin
          w_last_sym_n = in_sym;
          w_run_cnt_n  = RW'(1);
          w_state_n    = RUN;
        end

        RUN: begin
          if (!w_same) begin
            // A mismatching symbol is the first symbol of a new run.
            w_last_sym_n = in_sym;
            w_run_cnt_n  = RW'(1);
          end else if (!w_run_done) begin
            w_run_cnt_n = w_run_cnt_inc;
          end else begin
            w_hit_n     = 1'b1;
            w_hit_sym_n = in_sym;
            if (overlap) begin
              w_state_n   = FULL;
              w_run_cnt_n = RW'(RUN_LEN);
            end else begin
              w_state_n   = IDLE;
              w_run_cnt_n = '0;
            end
          end
        end

        FULL: begin
          if (w_same) begin
            if (overlap) begin
              // Every further matching symbol completes another window.
              w_hit_n     = 1'b1;
              w_hit_sym_n = in_sym;
            end else begin
              // Leaving overlap mode: this symbol opens a fresh run.
              w_state_n   = RUN;
              w_run_cnt_n = RW'(1);
            end
          end else begin
            w_state_n    = RUN;
            w_run_cnt_n  = RW'(1);
            w_last_sym_n = in_sym;
          end
        end

        default: begin
          w_state_n   = IDLE;
          w_run_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_run_cnt  <= '0;
      r_last_sym <= '0;
      r_hit      <= 1'b0;
      r_hit_sym  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_run_cnt  <= w_run_cnt_n;
      r_last_sym <= w_last_sym_n;
      r_hit      <= w_hit_n;
      r_hit_sym  <= w_hit_sym_n;
    end
  end

  // The counter steps on the same edge that raises hit, so hit_count already
  // includes a hit while that hit is being shown.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit_n),
    .clr   (clear),
    .count (hit_count)
  );

  assign hit       = r_hit;
  assign hit_sym   = r_hit_sym;
  assign run_cnt   = r_run_cnt;
  assign dbg_state = r_state;

endmodule
